// File: rtl/gpio_irq_ctrl.sv
// Per-pin GPIO interrupt controller: pad synchroniser, prescaled debounce
// filter, level/edge event detection, sticky raw status with clear strobes,
// masked status and one combined interrupt line.
module gpio_irq_ctrl #(
    parameter int SZ      = 8,
    parameter int DB_W    = 8,
    parameter int PRESC_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [SZ-1:0]      GPIO_DIN,
    input  logic [SZ-1:0]      GPIO_OE,
    input  logic [SZ-1:0]      IM,
    input  logic [SZ-1:0]      TYPE,
    input  logic [SZ-1:0]      POL,
    input  logic [SZ-1:0]      BOTH,
    input  logic [SZ-1:0]      DB_EN,
    input  logic [DB_W-1:0]    DB_CNT,
    input  logic [PRESC_W-1:0] DB_PRESC,
    input  logic [SZ-1:0]      ICR,
    output logic [SZ-1:0]      DIN_SYNC,
    output logic [SZ-1:0]      RIS,
    output logic [SZ-1:0]      MIS,
    output logic               IRQ
);

    logic [SZ-1:0]            s1_q, s2_q;
    logic [SZ-1:0]            filt_q, filt_d;
    logic [SZ-1:0][DB_W-1:0]  dbc_q, dbc_d;
    logic [PRESC_W-1:0]       presc_q, presc_d;
    logic [SZ-1:0]            fd_q;
    logic [SZ-1:0]            ris_q, ris_d;
    logic [1:0]               arm_q, arm_d;

    logic                     tick;
    logic                     armed;
    logic [SZ-1:0]            f;
    logic [SZ-1:0]            rise, fall;
    logic [SZ-1:0]            ev_lvl, ev_edge, ev;

    // Two-flop synchroniser on the asynchronous pad inputs
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= GPIO_DIN;
            s2_q <= s1_q;
        end
    end

    // Debounce tick prescaler; a lowered DB_PRESC below the count wraps straight to 0
    always_comb begin
        tick    = (presc_q == DB_PRESC);
        presc_d = (presc_q >= DB_PRESC) ? '0 : presc_q + PRESC_W'(1);
    end

    // Per-pin debounce: count ticks while the synchronised value differs from the filter
    always_comb begin
        filt_d = filt_q;
        dbc_d  = dbc_q;
        for (int i = 0; i < SZ; i++) begin
            if (s2_q[i] == filt_q[i]) begin
                dbc_d[i] = '0;
            end else if (tick) begin
                // >= keeps the counter bounded when DB_CNT is lowered mid-count
                if (dbc_q[i] >= DB_CNT) begin
                    filt_d[i] = s2_q[i];
                    dbc_d[i]  = '0;
                end else begin
                    dbc_d[i] = dbc_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Filtered pin value, edge detection and event qualification
    always_comb begin
        f       = (DB_EN & filt_q) | (~DB_EN & s2_q);
        rise    = f & ~fd_q;
        fall    = ~f & fd_q;
        ev_lvl  = ~(f ^ POL);
        ev_edge = (BOTH & (rise | fall)) | (~BOTH & ((POL & rise) | (~POL & fall)));
        ev      = ((TYPE & ev_edge) | (~TYPE & ev_lvl)) & ~GPIO_OE & {SZ{armed}};
    end

    // Sticky status: a new event wins over a simultaneous clear strobe
    always_comb begin
        ris_d = ev | (ris_q & ~ICR);
    end

    // Arming counter holds off events until edge history is valid after reset
    always_comb begin
        armed = (arm_q == 2'd3);
        arm_d = armed ? arm_q : arm_q + 2'd1;
    end

    // State registers for filter, prescaler, edge history, status and arming
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            filt_q  <= '0;
            dbc_q   <= '0;
            presc_q <= '0;
            fd_q    <= '0;
            ris_q   <= '0;
            arm_q   <= '0;
        end else begin
            filt_q  <= filt_d;
            dbc_q   <= dbc_d;
            presc_q <= presc_d;
            fd_q    <= f;
            ris_q   <= ris_d;
            arm_q   <= arm_d;
        end
    end

    assign DIN_SYNC = f;
    assign RIS      = ris_q;
    assign MIS      = ris_q & IM;
    assign IRQ      = |(ris_q & IM);

endmodule
